// File: rtl/lock_sequencer.sv
// Combination-lock sequencer: stores secret data and a password, then checks entered candidates one digit per cycle.
// Latency: one cycle per transition; a password check takes exactly 8 cycles in CHECK.
// Backpressure: none; next_i is dropped while CHECK or LOCKOUT is active, tick_i is dropped outside timed states.
//
// Ports:
//   clk_i, rst_i        - single clock, synchronous active-high reset
//   next_i, tick_i      - one-cycle button press and timebase pulses
//   entry_i[31:0]       - eight BCD digits, digit1 in [3:0]
//   state_o[2:0]        - current state code
//   clear_o             - one-cycle request to zero the entry registers
//   busy_o, open_o, lockout_o - state decodes
//   attempts_o[2:0]     - consecutive failed attempts
//   data_o[31:0]        - stored data, zero unless open
//
// Optional feature: define LOCK_AUTO_RELOCK_EN to relock automatically after OPEN_TICKS tick_i pulses in OPEN.

module lock_sequencer #(
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter logic [15:0] LOCKOUT_TICKS = 16'd30000,
  parameter logic [15:0] OPEN_TICKS    = 16'd50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        next_i,
  input  logic        tick_i,
  input  logic [31:0] entry_i,
  output logic [2:0]  state_o,
  output logic        clear_o,
  output logic        busy_o,
  output logic        open_o,
  output logic        lockout_o,
  output logic [2:0]  attempts_o,
  output logic [31:0] data_o
);

  typedef enum logic [2:0] {
    ST_DATA    = 3'd0,
    ST_NEWPASS = 3'd1,
    ST_ARMED   = 3'd2,
    ST_PASS    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_OPEN    = 3'd5,
    ST_LOCKOUT = 3'd6
  } state_t;

  localparam logic [3:0] MAX_ATT = 4'(MAX_ATTEMPTS);

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] cand_q, cand_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic        mismatch_q, mismatch_d;
  logic [2:0]  attempts_q, attempts_d;
  logic        clear_q, clear_d;

  logic        digit_ne;
  logic        mismatch_final;
  logic [3:0]  attempts_inc;
  logic        timer_expire;

  // One digit per cycle; the final digit is folded in combinationally so
  // the decision is made on the 8th CHECK cycle without an extra state.
  assign digit_ne       = cand_q[{idx_q, 2'b00} +: 4] != pass_q[{idx_q, 2'b00} +: 4];
  assign mismatch_final = mismatch_q | digit_ne;
  assign attempts_inc   = {1'b0, attempts_q} + 4'd1;
  // A zero timer is treated as expired too, so a timed state can never stall.
  assign timer_expire   = tick_i && (timer_q <= 16'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_DATA;
      data_q     <= '0;
      pass_q     <= '0;
      cand_q     <= '0;
      timer_q    <= '0;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      attempts_q <= '0;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      pass_q     <= pass_d;
      cand_q     <= cand_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      attempts_q <= attempts_d;
      clear_q    <= clear_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    pass_d     = pass_q;
    cand_d     = cand_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    mismatch_d = mismatch_q;
    attempts_d = attempts_q;
    clear_d    = 1'b0;

    case (state_q)
      ST_DATA: begin
        if (next_i) begin
          data_d  = entry_i;
          state_d = ST_NEWPASS;
          clear_d = 1'b1;
        end
      end

      ST_NEWPASS: begin
        if (next_i) begin
          pass_d  = entry_i;
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (next_i) begin
          state_d = ST_PASS;
          clear_d = 1'b1;
        end
      end

      ST_PASS: begin
        if (next_i) begin
          cand_d     = entry_i;
          mismatch_d = 1'b0;
          idx_d      = 3'd0;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        mismatch_d = mismatch_final;
        if (idx_q == 3'd7) begin
          idx_d = 3'd0;
          if (!mismatch_final) begin
            attempts_d = 3'd0;
            // Loaded in every build; only the auto-relock build counts it down.
            timer_d    = OPEN_TICKS;
            state_d    = ST_OPEN;
          end else if (attempts_inc < MAX_ATT) begin
            attempts_d = attempts_inc[2:0];
            state_d    = ST_PASS;
            clear_d    = 1'b1;
          end else begin
            attempts_d = attempts_inc[2:0];
            timer_d    = LOCKOUT_TICKS;
            state_d    = ST_LOCKOUT;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      ST_LOCKOUT: begin
        if (timer_expire) begin
          timer_d    = 16'd0;
          attempts_d = 3'd0;
          state_d    = ST_PASS;
          clear_d    = 1'b1;
        end else if (tick_i) begin
          timer_d = timer_q - 16'd1;
        end
      end

      ST_OPEN: begin
`ifdef LOCK_AUTO_RELOCK_EN
        if (timer_expire) begin
          timer_d = 16'd0;
        end else if (tick_i) begin
          timer_d = timer_q - 16'd1;
        end
        // Press and expiry in the same cycle collapse into one relock.
        if (next_i || timer_expire) begin
          state_d = ST_ARMED;
        end
`else
        if (next_i) begin
          state_d = ST_ARMED;
        end
`endif
      end

      default: begin
        state_d = ST_DATA;
      end
    endcase
  end

  assign state_o    = state_q;
  assign clear_o    = clear_q;
  assign busy_o     = (state_q == ST_CHECK);
  assign open_o     = (state_q == ST_OPEN);
  assign lockout_o  = (state_q == ST_LOCKOUT);
  assign attempts_o = attempts_q;
  assign data_o     = (state_q == ST_OPEN) ? data_q : 32'd0;

endmodule
